branch_predictor_2bit: RTL and testbench

Parametrised direct-mapped branch predictor with per-entry 2-bit saturating counters, tags and stored targets, plus an optional gshare indexing mode and mispredict statistics. It sits beside the IF stage of the five-stage CPU. It gives a combinational taken/target prediction for the current fetch PC. The resolving stage writes it back one update per cycle. It supersedes the single-bit history/prediction table.

---
 rtl/branch_predictor_2bit.sv | 174 +++++++++++++++++
 tb/tb_branch_predictor_2bit.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_2bit.sv
// Direct-mapped branch predictor: per-entry 2-bit saturating counter, tag and target, optional gshare index.
// Latency: prediction is combinational (0 cycles); updates land on the next rising clk edge (1 cycle).
// Backpressure: none; accepts one update per cycle and the lookup path never stalls.
//
// Ports:
//   clk, rst         - clock and asynchronous active-high reset
//   pc_if            - fetch PC; drives pred_hit / pred_taken / pred_target / pred_idx
//   upd_*            - one resolved conditional branch per cycle when upd_valid=1
//   ghr              - global history (always 0 in bimodal mode)
//   n_updates        - saturating count of accepted updates
//   n_mispred        - saturating count of updates whose captured prediction was wrong
module branch_predictor_2bit #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int ADDR_W  = 32,
    parameter int GSHARE  = 0,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_if,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    output logic [IDX_W-1:0]  ghr,
    output logic [CNT_W-1:0]  n_updates,
    output logic [CNT_W-1:0]  n_mispred
);

    // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
    localparam logic [1:0] CNT_RST   = 2'b01;
    localparam logic [1:0] CNT_ALLOC = 2'b10;
    localparam logic [1:0] CNT_MAX   = 2'b11;
    localparam logic [1:0] CNT_MIN   = 2'b00;

    // Elaboration-time parameter sanity.
    if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("ENTRIES must be a power of two and at least 4");
    end
    if (ADDR_W < IDX_W + TAG_W + 2) begin : g_bad_addr
        $error("ADDR_W too narrow for index plus tag bits");
    end

    // ------------------------------------------------------------------
    // Table and bookkeeping state
    // ------------------------------------------------------------------
    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [1:0]        cnt_q   [ENTRIES];
    logic [ADDR_W-1:0] tgt_q   [ENTRIES];

    logic [IDX_W-1:0]  ghr_q,   ghr_d;
    logic [CNT_W-1:0]  n_upd_q, n_upd_d;
    logic [CNT_W-1:0]  n_mis_q, n_mis_d;

    // ------------------------------------------------------------------
    // Lookup path (purely combinational from stored state, no bypass)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;

    // ghr_q is held at zero in bimodal mode, so the XOR is transparent there.
    assign lk_idx = pc_if[IDX_W+1:2] ^ ghr_q;
    assign lk_tag = pc_if[IDX_W+TAG_W+1:IDX_W+2];

    assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit && cnt_q[lk_idx][1];
    assign pred_target = pred_hit ? tgt_q[lk_idx] : '0;
    assign pred_idx    = lk_idx;
    assign ghr         = ghr_q;
    assign n_updates   = n_upd_q;
    assign n_mispred   = n_mis_q;

    // PC bits outside the index/tag fields are intentionally ignored (aliasing).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_if, upd_pc};

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              wr_en;
    logic [1:0]        cnt_d;
    logic [ADDR_W-1:0] tgt_d;

    assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        wr_en = 1'b0;
        cnt_d = cnt_q[upd_idx];
        tgt_d = tgt_q[upd_idx];
        if (upd_valid) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    cnt_d = (cnt_q[upd_idx] == CNT_MAX) ? CNT_MAX : cnt_q[upd_idx] + 2'd1;
                    tgt_d = upd_target;
                end else begin
                    cnt_d = (cnt_q[upd_idx] == CNT_MIN) ? CNT_MIN : cnt_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Taken miss allocates, evicting whatever lived at this index.
                wr_en = 1'b1;
                cnt_d = CNT_ALLOC;
                tgt_d = upd_target;
            end
            // A not-taken miss leaves the table untouched.
        end
    end

    // History is non-speculative: it only moves with resolved outcomes.
    always_comb begin
        ghr_d = ghr_q;
        if (GSHARE != 0 && upd_valid) begin
            ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
        end
    end

    // Statistics saturate at all-ones rather than wrapping.
    always_comb begin
        n_upd_d = n_upd_q;
        n_mis_d = n_mis_q;
        if (upd_valid) begin
            if (n_upd_q != '1) begin
                n_upd_d = n_upd_q + CNT_W'(1);
            end
            if ((upd_pred_taken != upd_taken) && (n_mis_q != '1)) begin
                n_mis_d = n_mis_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                cnt_q[i]   <= CNT_RST;
                tgt_q[i]   <= '0;
            end
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            cnt_q[upd_idx]   <= cnt_d;
            tgt_q[upd_idx]   <= tgt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q   <= '0;
            n_upd_q <= '0;
            n_mis_q <= '0;
        end else begin
            ghr_q   <= ghr_d;
            n_upd_q <= n_upd_d;
            n_mis_q <= n_mis_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Testbench for branch_predictor_2bit: bimodal, gshare and narrow-statistics instances share one stimulus stream.
// Latency: checks lookups combinationally before the edge and table/stat state 1 ns after it.
// Backpressure: none; the bench drives at most one update per cycle.
module tb_branch_predictor_2bit;

    localparam int N = 3;   // 0: bimodal default, 1: gshare, 2: CNT_W=2

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if, upd_pc, upd_target;
    logic [3:0]  upd_idx;
    logic        upd_valid, upd_taken, upd_pred_taken;

    logic        ph   [N];
    logic        pt   [N];
    logic [31:0] ptg  [N];
    logic [3:0]  pidx [N];
    logic [3:0]  pghr [N];
    logic [15:0] nu0, nm0, nu1, nm1;
    logic [1:0]  nu2, nm2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor_2bit u0 (
        .clk(clk), .rst(rst), .pc_if(pc_if),
        .pred_hit(ph[0]), .pred_taken(pt[0]), .pred_target(ptg[0]), .pred_idx(pidx[0]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .ghr(pghr[0]), .n_updates(nu0), .n_mispred(nm0)
    );

    branch_predictor_2bit #(.GSHARE(1)) u1 (
        .clk(clk), .rst(rst), .pc_if(pc_if),
        .pred_hit(ph[1]), .pred_taken(pt[1]), .pred_target(ptg[1]), .pred_idx(pidx[1]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .ghr(pghr[1]), .n_updates(nu1), .n_mispred(nm1)
    );

    branch_predictor_2bit #(.CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .pc_if(pc_if),
        .pred_hit(ph[2]), .pred_taken(pt[2]), .pred_target(ptg[2]), .pred_idx(pidx[2]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .ghr(pghr[2]), .n_updates(nu2), .n_mispred(nm2)
    );

    // ------------------------------------------------------------------
    // Reference model: plain integers, one table per instance
    // ------------------------------------------------------------------
    bit          m_valid [N][16];
    int          m_tag   [N][16];
    int          m_cnt   [N][16];
    logic [31:0] m_tgt   [N][16];
    int          m_ghr   [N];
    int          m_nu    [N];
    int          m_nm    [N];

    function automatic void m_reset();
        for (int d = 0; d < N; d++) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[d][i] = 1'b0;
                m_tag[d][i]   = 0;
                m_cnt[d][i]   = 1;
                m_tgt[d][i]   = 32'h0;
            end
            m_ghr[d] = 0;
            m_nu[d]  = 0;
            m_nm[d]  = 0;
        end
    endfunction

    function automatic void m_lookup(input int d, input logic [31:0] pc,
                                     output logic hit, output logic taken,
                                     output logic [31:0] tgt, output int idx);
        int tg;
        idx   = int'((pc >> 2) & 32'hF) ^ m_ghr[d];
        tg    = int'((pc >> 6) & 32'hFF);
        hit   = m_valid[d][idx] && (m_tag[d][idx] == tg);
        taken = hit && (m_cnt[d][idx] >= 2);
        tgt   = hit ? m_tgt[d][idx] : 32'h0;
    endfunction

    function automatic void m_update(input int d);
        int i, tg, mx;
        if (!upd_valid) return;
        i  = int'(upd_idx);
        tg = int'((upd_pc >> 6) & 32'hFF);
        if (m_valid[d][i] && m_tag[d][i] == tg) begin
            if (upd_taken) begin
                if (m_cnt[d][i] < 3) m_cnt[d][i] = m_cnt[d][i] + 1;
                m_tgt[d][i] = upd_target;
            end else if (m_cnt[d][i] > 0) begin
                m_cnt[d][i] = m_cnt[d][i] - 1;
            end
        end else if (upd_taken) begin
            m_valid[d][i] = 1'b1;
            m_tag[d][i]   = tg;
            m_cnt[d][i]   = 2;
            m_tgt[d][i]   = upd_target;
        end
        if (d == 1) m_ghr[d] = (m_ghr[d] * 2 + int'(upd_taken)) % 16;
        mx = (d == 2) ? 3 : 65535;
        if (m_nu[d] < mx) m_nu[d] = m_nu[d] + 1;
        if (upd_taken != upd_pred_taken && m_nm[d] < mx) m_nm[d] = m_nm[d] + 1;
    endfunction

    function automatic logic [31:0] dut_nu(input int d);
        case (d)
            0:       return {16'h0, nu0};
            1:       return {16'h0, nu1};
            default: return {30'h0, nu2};
        endcase
    endfunction

    function automatic logic [31:0] dut_nm(input int d);
        case (d)
            0:       return {16'h0, nm0};
            1:       return {16'h0, nm1};
            default: return {30'h0, nm2};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no comparisons here)
    // ------------------------------------------------------------------
    task automatic set_upd(input logic [31:0] pc, input logic [3:0] idx, input logic t,
                           input logic [31:0] tg, input logic ptk);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_idx        = idx;
        upd_taken      = t;
        upd_target     = tg;
        upd_pred_taken = ptk;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int d = 0; d < N; d++) m_update(d);
        end
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic probe(input logic [31:0] pc);
        pc_if = pc;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_reset();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_idx = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; pc_if = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            checks++; if (ph[d] !== 1'b0) begin errors++; $display("FAIL reset_hit[%0d] got %b exp 0", d, ph[d]); end
            checks++; if (pt[d] !== 1'b0) begin errors++; $display("FAIL reset_taken[%0d] got %b exp 0", d, pt[d]); end
            checks++; if (ptg[d] !== 32'h0) begin errors++; $display("FAIL reset_target[%0d] got %h exp 0", d, ptg[d]); end
            checks++; if (dut_nu(d) !== 32'h0) begin errors++; $display("FAIL reset_nupd[%0d] got %0d exp 0", d, dut_nu(d)); end
            checks++; if (pghr[d] !== 4'h0) begin errors++; $display("FAIL reset_ghr[%0d] got %h exp 0", d, pghr[d]); end
        end
        probe(32'h4C);
        checks++; if (pidx[1] !== 4'h3) begin errors++; $display("FAIL reset_pred_idx got %h exp 3", pidx[1]); end
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_allocate();
        pc_if = 32'h40;
        set_upd(32'h40, 4'h0, 1'b1, 32'h100, 1'b0);
        #1;
        checks++; if (ph[0] !== 1'b0) begin errors++; $display("FAIL no_bypass_hit got %b exp 0", ph[0]); end
        tick();
        probe(32'h40);
        for (int d = 0; d < N; d += 2) begin
            checks++; if (ph[d] !== 1'b1) begin errors++; $display("FAIL alloc_hit[%0d] got %b exp 1", d, ph[d]); end
            checks++; if (pt[d] !== 1'b1) begin errors++; $display("FAIL alloc_taken[%0d] got %b exp 1", d, pt[d]); end
            checks++; if (ptg[d] !== 32'h100) begin errors++; $display("FAIL alloc_target[%0d] got %h exp 100", d, ptg[d]); end
        end
    endtask

    task automatic test_counter();
        for (int k = 0; k < 3; k++) begin
            set_upd(32'h40, 4'h0, 1'b0, 32'hDEAD, 1'b1);
            tick();
            probe(32'h40);
            checks++; if (pt[0] !== 1'b0) begin errors++; $display("FAIL nt_step%0d_taken got %b exp 0", k, pt[0]); end
            checks++; if (ph[0] !== 1'b1) begin errors++; $display("FAIL nt_step%0d_hit got %b exp 1", k, ph[0]); end
        end
        set_upd(32'h40, 4'h0, 1'b1, 32'h180, 1'b0);
        tick();
        probe(32'h40);
        checks++; if (pt[0] !== 1'b0) begin errors++; $display("FAIL sat_low_taken got %b exp 0", pt[0]); end
        checks++; if (ptg[0] !== 32'h180) begin errors++; $display("FAIL hit_taken_target got %h exp 180", ptg[0]); end
    endtask

    task automatic test_back_to_back();
        // Entry 0 sits at weak-NT; two consecutive taken updates reach strong-T.
        set_upd(32'h40, 4'h0, 1'b1, 32'h180, 1'b0);
        tick();
        set_upd(32'h40, 4'h0, 1'b1, 32'h180, 1'b0);
        tick();
        set_upd(32'h40, 4'h0, 1'b0, 32'h0, 1'b1);
        tick();
        probe(32'h40);
        checks++; if (pt[0] !== 1'b1) begin errors++; $display("FAIL b2b_strong_taken got %b exp 1", pt[0]); end
        set_upd(32'h40, 4'h0, 1'b0, 32'h0, 1'b1);
        tick();
        probe(32'h40);
        checks++; if (pt[0] !== 1'b0) begin errors++; $display("FAIL b2b_weak_nt got %b exp 0", pt[0]); end
    endtask

    task automatic test_tag_conflict();
        set_upd(32'h440, 4'h0, 1'b1, 32'h300, 1'b0);
        tick();
        probe(32'h40);
        checks++; if (ph[0] !== 1'b0) begin errors++; $display("FAIL conflict_old_hit got %b exp 0", ph[0]); end
        probe(32'h440);
        checks++; if (ph[0] !== 1'b1) begin errors++; $display("FAIL conflict_new_hit got %b exp 1", ph[0]); end
        checks++; if (ptg[0] !== 32'h300) begin errors++; $display("FAIL conflict_new_target got %h exp 300", ptg[0]); end
        set_upd(32'h840, 4'h0, 1'b0, 32'h999, 1'b1);
        tick();
        probe(32'h440);
        checks++; if (ph[0] !== 1'b1 || pt[0] !== 1'b1 || ptg[0] !== 32'h300) begin
            errors++; $display("FAIL nt_miss_nowrite got hit=%b taken=%b tgt=%h exp 1 1 300", ph[0], pt[0], ptg[0]);
        end
        // One not-taken from the freshly allocated weak-T must drop to not-taken.
        set_upd(32'h440, 4'h0, 1'b0, 32'h0, 1'b1);
        tick();
        probe(32'h440);
        checks++; if (pt[0] !== 1'b0) begin errors++; $display("FAIL alloc_cnt_weak got %b exp 0", pt[0]); end
    endtask

    task automatic test_gshare();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_upd(32'h1000, 4'h3, 1'b1, 32'h500, 1'b0);
            tick();
        end
        checks++; if (pghr[1] !== 4'h7) begin errors++; $display("FAIL gshare_ghr got %h exp 7", pghr[1]); end
        checks++; if (pghr[0] !== 4'h0) begin errors++; $display("FAIL bimodal_ghr got %h exp 0", pghr[0]); end
        probe(32'h40);
        checks++; if (pidx[1] !== 4'h7) begin errors++; $display("FAIL gshare_idx got %h exp 7", pidx[1]); end
        checks++; if (pidx[0] !== 4'h0) begin errors++; $display("FAIL bimodal_idx got %h exp 0", pidx[0]); end
        set_upd(32'h40, 4'h7, 1'b1, 32'h200, 1'b0);
        tick();
        // ghr is now 1111: pc 0x60 (bits 8) maps to entry 7 with the tag of 0x40.
        probe(32'h60);
        checks++; if (ph[1] !== 1'b1 || ptg[1] !== 32'h200) begin
            errors++; $display("FAIL gshare_entry7 got hit=%b tgt=%h exp 1 200", ph[1], ptg[1]);
        end
        probe(32'h40);
        checks++; if (ph[1] !== 1'b0) begin errors++; $display("FAIL gshare_idx15_hit got %b exp 0", ph[1]); end
        probe(32'h1030);
        checks++; if (ph[1] !== 1'b1 || ptg[1] !== 32'h500) begin
            errors++; $display("FAIL gshare_entry3_kept got hit=%b tgt=%h exp 1 500", ph[1], ptg[1]);
        end
    endtask

    task automatic test_stats();
        logic t_seq  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic pt_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        @(posedge clk); #1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_upd(32'h80 + 32'(k * 4), 4'(k + 2), t_seq[k], 32'h700, pt_seq[k]);
            tick();
        end
        checks++; if (nu0 !== 16'd5) begin errors++; $display("FAIL stats_nupd got %0d exp 5", nu0); end
        checks++; if (nm0 !== 16'd2) begin errors++; $display("FAIL stats_nmis got %0d exp 2", nm0); end
        checks++; if (nu1 !== 16'd5) begin errors++; $display("FAIL stats_nupd_gs got %0d exp 5", nu1); end
        checks++; if (nu2 !== 2'd3) begin errors++; $display("FAIL stats_nupd_sat got %0d exp 3", nu2); end
        checks++; if (nm2 !== 2'd2) begin errors++; $display("FAIL stats_nmis_cw2 got %0d exp 2", nm2); end
    endtask

    task automatic test_reset_discard();
        @(posedge clk); #1;
        set_upd(32'h40, 4'h0, 1'b1, 32'h100, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        upd_valid = 1'b0;
        m_reset();
        probe(32'h40);
        checks++; if (ph[0] !== 1'b0) begin errors++; $display("FAIL rst_discard_hit got %b exp 0", ph[0]); end
        checks++; if (nu0 !== 16'd0) begin errors++; $display("FAIL rst_discard_nupd got %0d exp 0", nu0); end
        checks++; if (pghr[1] !== 4'h0) begin errors++; $display("FAIL rst_discard_ghr got %h exp 0", pghr[1]); end
    endtask

    task automatic test_random();
        logic        e_hit, e_taken;
        logic [31:0] e_tgt;
        int          e_idx;
        logic [31:0] rpc;
        @(posedge clk); #1;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            // Small PC pool (4 tags x 4 indices) plus an ignored high bit to force aliasing.
            rpc   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
                  | (32'($urandom_range(0, 1)) << 14);
            pc_if = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
                  | (32'($urandom_range(0, 1)) << 15);
            set_upd(rpc, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : rpc[5:2],
                    1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
            upd_valid = ($urandom_range(0, 3) != 0);
            #1;
            for (int d = 0; d < N; d++) begin
                m_lookup(d, pc_if, e_hit, e_taken, e_tgt, e_idx);
                checks++; if (ph[d] !== e_hit) begin errors++; $display("FAIL rnd_hit[%0d] n=%0d got %b exp %b", d, n, ph[d], e_hit); end
                checks++; if (pt[d] !== e_taken) begin errors++; $display("FAIL rnd_taken[%0d] n=%0d got %b exp %b", d, n, pt[d], e_taken); end
                checks++; if (ptg[d] !== e_tgt) begin errors++; $display("FAIL rnd_target[%0d] n=%0d got %h exp %h", d, n, ptg[d], e_tgt); end
                checks++; if (pidx[d] !== 4'(e_idx)) begin errors++; $display("FAIL rnd_idx[%0d] n=%0d got %h exp %h", d, n, pidx[d], 4'(e_idx)); end
            end
            tick();
            for (int d = 0; d < N; d++) begin
                checks++; if (pghr[d] !== 4'(m_ghr[d])) begin errors++; $display("FAIL rnd_ghr[%0d] n=%0d got %h exp %h", d, n, pghr[d], 4'(m_ghr[d])); end
                checks++; if (dut_nu(d) !== 32'(m_nu[d])) begin errors++; $display("FAIL rnd_nupd[%0d] n=%0d got %0d exp %0d", d, n, dut_nu(d), m_nu[d]); end
                checks++; if (dut_nm(d) !== 32'(m_nm[d])) begin errors++; $display("FAIL rnd_nmis[%0d] n=%0d got %0d exp %0d", d, n, dut_nm(d), m_nm[d]); end
            end
        end
    endtask

    task automatic test_async_reset();
        set_upd(32'h40, 4'h0, 1'b1, 32'h100, 1'b0);
        tick();
        probe(32'h40);
        checks++; if (ph[0] !== 1'b1) begin errors++; $display("FAIL pre_arst_hit got %b exp 1", ph[0]); end
        // Raise rst mid-cycle, well away from any clock edge.
        #1;
        rst = 1'b1;
        #1;
        checks++; if (nu0 !== 16'd0 || nm0 !== 16'd0) begin errors++; $display("FAIL arst_stats got %0d %0d exp 0 0", nu0, nm0); end
        checks++; if (nu2 !== 2'd0) begin errors++; $display("FAIL arst_stats_cw2 got %0d exp 0", nu2); end
        checks++; if (ph[0] !== 1'b0 || ptg[0] !== 32'h0) begin errors++; $display("FAIL arst_lookup got hit=%b tgt=%h exp 0 0", ph[0], ptg[0]); end
        checks++; if (pghr[1] !== 4'h0) begin errors++; $display("FAIL arst_ghr got %h exp 0", pghr[1]); end
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_counter();
        test_back_to_back();
        test_tag_conflict();
        test_gshare();
        test_stats();
        test_reset_discard();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
